// File: rtl/cgra_config_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | cgra_seq_pkg : shared state encoding and counter sizing helpers      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package cgra_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST       = 3'd1,
    LOAD      = 3'd2,
    WAIT_DONE = 3'd3,
    RUN       = 3'd4,
    FIN       = 3'd5
  } state_e;

  // Width able to hold the value n itself (not just n-1).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_TOTAL_NUM_BITS = 772;
  localparam int DEF_DONE_TIMEOUT   = 4;
  localparam int BIT_CNT_W          = $clog2(DEF_TOTAL_NUM_BITS + 1);
  localparam int WAIT_CNT_W         = $clog2(DEF_DONE_TIMEOUT + 1);

endpackage

`default_nettype wire

// File: rtl/seq_cycle_counter.sv
// +----------------------------------------------------------------------+
// | seq_cycle_counter : loadable up-counter with clear and match flag    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_cycle_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic [WIDTH-1:0] i_match_value,
  output logic             o_match
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = i_load_value;
    end else if (i_enable) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_match = (count_q == i_match_value);

endmodule

`default_nettype wire

// File: rtl/cgra_config_sequencer.sv
// +----------------------------------------------------------------------+
// | cgra_config_sequencer : loads the CGRA config chain, then runs array |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module cgra_config_sequencer
  import cgra_seq_pkg::*;
#(
  parameter int TOTAL_NUM_BITS = 772,
  parameter int RUN_CNT_W      = 32,
  parameter int DONE_TIMEOUT   = 4
) (
  input  logic                 clock,
  input  logic                 sync_reset,
  input  logic                 start,
  input  logic [RUN_CNT_W-1:0] run_cycles,
  input  logic                 stop,
  output logic                 cfgr_sync_reset,
  output logic                 cfgr_enable,
  input  logic                 cfgr_bitstream,
  input  logic                 cfgr_done,
  output logic                 cgra_config_in,
  output logic                 cgra_config_enable,
  output logic                 cgra_reset,
  output logic                 cgra_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int BIT_W  = cnt_width(TOTAL_NUM_BITS);
  localparam int WAIT_W = cnt_width(DONE_TIMEOUT);

  state_e                 state_q, state_d;
  logic                   error_q, error_d;
  logic                   cfg_en_q, cfg_en_d;
  logic [RUN_CNT_W-1:0]   run_n_q, run_n_d;

  logic w_bit_last;
  logic w_wait_last;
  logic w_run_last;
  logic w_active;

  seq_cycle_counter #(.WIDTH(BIT_W)) u_bit_cnt (
    .clk          (clock),
    .rst          (sync_reset),
    .i_clear      (state_q != LOAD),
    .i_enable     (state_q == LOAD),
    .i_load       (1'b0),
    .i_load_value ('0),
    .i_match_value(BIT_W'(TOTAL_NUM_BITS - 1)),
    .o_match      (w_bit_last)
  );

  seq_cycle_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk          (clock),
    .rst          (sync_reset),
    .i_clear      (state_q != WAIT_DONE),
    .i_enable     (state_q == WAIT_DONE),
    .i_load       (1'b0),
    .i_load_value ('0),
    .i_match_value(WAIT_W'(DONE_TIMEOUT - 1)),
    .o_match      (w_wait_last)
  );

  seq_cycle_counter #(.WIDTH(RUN_CNT_W)) u_run_cnt (
    .clk          (clock),
    .rst          (sync_reset),
    .i_clear      (state_q != RUN),
    .i_enable     (state_q == RUN),
    .i_load       (1'b0),
    .i_load_value ('0),
    .i_match_value(run_n_q - RUN_CNT_W'(1)),
    .o_match      (w_run_last)
  );

  // stop takes priority over configurator status in the load phases
  always_comb begin
    state_d  = state_q;
    error_d  = error_q;
    run_n_d  = run_n_q;
    cfg_en_d = (state_q == LOAD);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RST;
          error_d = 1'b0;
          run_n_d = run_cycles;
        end
      end
      RST: begin
        state_d = stop ? IDLE : LOAD;
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cfgr_done) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else if (w_bit_last) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cfgr_done) begin
          state_d = RUN;
        end else if (w_wait_last) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      RUN: begin
        if (stop || ((run_n_q != '0) && w_run_last)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (sync_reset) begin
      state_q  <= IDLE;
      error_q  <= 1'b0;
      cfg_en_q <= 1'b0;
      run_n_q  <= '0;
    end else begin
      state_q  <= state_d;
      error_q  <= error_d;
      cfg_en_q <= cfg_en_d;
      run_n_q  <= run_n_d;
    end
  end

  // Outputs are forced quiet in the very first reset cycle as well.
  assign w_active           = ~sync_reset;
  assign cfgr_sync_reset    = sync_reset | (state_q == RST);
  assign cgra_reset         = sync_reset | (state_q == RST);
  assign cfgr_enable        = w_active & (state_q == LOAD);
  assign cgra_config_enable = w_active & cfg_en_q;
  assign cgra_config_in     = cfgr_bitstream;
  assign cgra_enable        = w_active & (state_q == RUN);
  assign busy               = w_active & (state_q != IDLE);
  assign done               = w_active & (state_q == FIN);
  assign error              = w_active & error_q;

endmodule

`default_nettype wire
